// File: rtl/mem_arbiter_pkg.sv
// Shared constants and FIFO entry layout for the memory-interface arbiter.
package mem_arbiter_pkg;

   localparam int unsigned TX_CMD_BITS = 3;

   localparam logic [TX_CMD_BITS-1:0] TX_HEADER_READ_16  = 3'd1;
   localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_16 = 3'd2;
   localparam logic [TX_CMD_BITS-1:0] TX_HEADER_WRITE_8  = 3'd3;

   localparam int unsigned ENTRY_BITS  = 2;
   localparam int unsigned ENTRY_REPLY = 1;
   localparam int unsigned ENTRY_IS_SC = 0;

   // A jump fetch is issued by SC but its response belongs to PF.
   function automatic logic [ENTRY_BITS-1:0] make_entry(logic sc_tx, logic reply_wanted,
                                                         logic write_pc);
      logic [ENTRY_BITS-1:0] e;
      e              = '0;
      e[ENTRY_REPLY] = sc_tx ? reply_wanted : 1'b1;
      e[ENTRY_IS_SC] = sc_tx & ~write_pc;
      return e;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// TX/RX channel between the arbiter (master) and the memory interface (slave).
interface mem_arbiter_if #(
   parameter int unsigned IO_BITS = 2
);
   import mem_arbiter_pkg::*;

   logic                   tx_command_valid;
   logic [TX_CMD_BITS-1:0] tx_command;
   logic [IO_BITS-1:0]     tx_data;
   logic                   tx_command_started;
   logic                   tx_active;
   logic                   rx_done;

   modport master (
      output tx_command_valid, tx_command, tx_data,
      input  tx_command_started, tx_active, rx_done
   );

   modport slave (
      input  tx_command_valid, tx_command, tx_data,
      output tx_command_started, tx_active, rx_done
   );

endinterface

// File: rtl/mem_arbiter_fifo.sv
// In-order transaction FIFO; a pop while empty is ignored, a push while full is dropped.
module mem_arbiter_fifo #(
   parameter int unsigned  BITS  = 2,
   parameter int unsigned  DEPTH = 4,
   localparam int unsigned CW    = $clog2(DEPTH + 1),
   localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            add,
   input  logic            remove,
   input  logic [BITS-1:0] new_entry,
   output logic [BITS-1:0] last_entry,
   output logic            empty,
   output logic            full,
   output logic [CW-1:0]   count
);

   logic [BITS-1:0] mem_q [DEPTH];
   logic [PW-1:0]   wr_q, rd_q;
   logic [CW-1:0]   cnt_q;
   logic            do_push, do_pop;

   function automatic logic [PW-1:0] next_ptr(logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign empty      = (cnt_q == '0);
   assign full       = (cnt_q == CW'(DEPTH));
   assign count      = cnt_q;
   assign last_entry = mem_q[rd_q];
   assign do_pop     = remove & ~empty;
   assign do_push    = add & (~full | do_pop);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= new_entry;
            wr_q        <= next_ptr(wr_q);
         end
         if (do_pop) rd_q <= next_ptr(rd_q);
         if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
         else if (!do_push && do_pop) cnt_q <= cnt_q - CW'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// PF/SC arbiter for the shared memory TX channel with in-order RX steering.
// Define MEM_ARB_FAIR_EN to force a PF grant after STARVE_LIMIT consecutive SC messages.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned  IO_BITS         = 2,
   parameter int unsigned  MAX_OUTSTANDING = 4,
   parameter int unsigned  STARVE_LIMIT    = 3,
   localparam int unsigned CNT_BITS        = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pf_cmd_valid,
   input  logic [TX_CMD_BITS-1:0] pf_cmd,
   input  logic [IO_BITS-1:0]     pf_data,
   input  logic                   sc_cmd_valid,
   input  logic [TX_CMD_BITS-1:0] sc_cmd,
   input  logic [IO_BITS-1:0]     sc_data,
   input  logic                   sc_reply_wanted,
   input  logic                   sc_reserve,
   input  logic                   sc_block,
   input  logic                   write_pc,
   mem_arbiter_if.master          mem,
   output logic                   sc_tx,
   output logic                   sc_rx,
   output logic                   pf_rx,
   output logic                   tx_fetch,
   output logic                   tx_jump,
   output logic                   prefetch_idle,
   output logic                   full,
   output logic                   empty,
   output logic [CNT_BITS-1:0]    outstanding,
   output logic                   err_underflow
);

   logic                  curr_sc_q;
   logic                  err_q;
   logic                  sc_want;
   logic                  starved;
   logic                  owner_valid;
   logic                  tracked;
   logic [ENTRY_BITS-1:0] head;

`ifdef MEM_ARB_FAIR_EN
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_q;

   // Reserve and block keep SC ownership even when PF is starved.
   assign starved = (starve_q == SW'(STARVE_LIMIT)) & ~sc_reserve & ~sc_block;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_q <= '0;
      end else if (mem.tx_command_started) begin
         if (!sc_tx)                                              starve_q <= '0;
         else if (pf_cmd_valid && starve_q != SW'(STARVE_LIMIT)) starve_q <= starve_q + SW'(1);
      end
   end
`else
   assign starved = 1'b0;
`endif

   assign sc_want       = (sc_cmd_valid | sc_reserve | sc_block) & ~starved;
   assign sc_tx         = mem.tx_active ? curr_sc_q : sc_want;
   assign prefetch_idle = mem.tx_active ? curr_sc_q : sc_block;
   assign tx_fetch      = ~sc_tx | write_pc;
   assign tx_jump       = write_pc;

   assign owner_valid          = sc_tx ? sc_cmd_valid : pf_cmd_valid;
   assign mem.tx_command       = sc_tx ? sc_cmd : pf_cmd;
   assign mem.tx_data          = sc_tx ? sc_data : pf_data;
   assign tracked              = (mem.tx_command == TX_HEADER_READ_16);
   // Only reads need a FIFO slot, so writes pass even when full.
   assign mem.tx_command_valid = owner_valid & ~(full & tracked);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         curr_sc_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (!mem.tx_active)      curr_sc_q <= sc_want;
         if (mem.rx_done && empty) err_q     <= 1'b1;
      end
   end

   assign err_underflow = err_q;

   mem_arbiter_fifo #(
      .BITS  (ENTRY_BITS),
      .DEPTH (MAX_OUTSTANDING)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .add        (mem.tx_command_started & tracked),
      .remove     (mem.rx_done),
      .new_entry  (make_entry(sc_tx, sc_reply_wanted, write_pc)),
      .last_entry (head),
      .empty      (empty),
      .full       (full),
      .count      (outstanding)
   );

   assign sc_rx = ~empty & head[ENTRY_REPLY] & head[ENTRY_IS_SC];
   assign pf_rx = ~empty & head[ENTRY_REPLY] & ~head[ENTRY_IS_SC];

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a queue-based reference model.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned STARVE = 3;

   logic                   clk;
   logic                   reset;
   logic                   pf_cmd_valid, sc_cmd_valid;
   logic [TX_CMD_BITS-1:0] pf_cmd, sc_cmd;
   logic [1:0]             pf_data, sc_data;
   logic                   sc_reply_wanted, sc_reserve, sc_block, write_pc;
   logic                   sc_tx, sc_rx, pf_rx, tx_fetch, tx_jump, prefetch_idle;
   logic                   full, empty, err_underflow;
   logic [2:0]             outstanding;

   mem_arbiter_if #(.IO_BITS(2)) bus ();

   mem_arbiter #(
      .IO_BITS         (2),
      .MAX_OUTSTANDING (DEPTH),
      .STARVE_LIMIT    (STARVE)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .pf_cmd_valid    (pf_cmd_valid),
      .pf_cmd          (pf_cmd),
      .pf_data         (pf_data),
      .sc_cmd_valid    (sc_cmd_valid),
      .sc_cmd          (sc_cmd),
      .sc_data         (sc_data),
      .sc_reply_wanted (sc_reply_wanted),
      .sc_reserve      (sc_reserve),
      .sc_block        (sc_block),
      .write_pc        (write_pc),
      .mem             (bus),
      .sc_tx           (sc_tx),
      .sc_rx           (sc_rx),
      .pf_rx           (pf_rx),
      .tx_fetch        (tx_fetch),
      .tx_jump         (tx_jump),
      .prefetch_idle   (prefetch_idle),
      .full            (full),
      .empty           (empty),
      .outstanding     (outstanding),
      .err_underflow   (err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: queue of {reply, is_sc} entries plus latched owner.
   logic [1:0] mq [$];
   bit         m_curr_sc, m_err;
   int         m_starve;

   bit             e_want, e_sc_tx, e_valid, e_sc_rx, e_pf_rx, e_fetch, e_jump, e_idle;
   bit             e_full, e_empty;
   int             e_out;
   logic [TX_CMD_BITS-1:0] e_cmd;
   logic [1:0]     e_data;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_curr_sc = 0;
      m_err     = 0;
      m_starve  = 0;
   endtask

   task automatic model_comb();
      bit owner_v;
      e_want = sc_cmd_valid | sc_reserve | sc_block;
`ifdef MEM_ARB_FAIR_EN
      if (m_starve == STARVE && !sc_reserve && !sc_block) e_want = 0;
`endif
      e_sc_tx = bus.tx_active ? m_curr_sc : e_want;
      owner_v = e_sc_tx ? sc_cmd_valid : pf_cmd_valid;
      e_cmd   = e_sc_tx ? sc_cmd : pf_cmd;
      e_data  = e_sc_tx ? sc_data : pf_data;
      e_out   = mq.size();
      e_full  = (mq.size() == DEPTH);
      e_empty = (mq.size() == 0);
      e_valid = owner_v && !(e_full && e_cmd == TX_HEADER_READ_16);
      e_sc_rx = 0;
      e_pf_rx = 0;
      if (mq.size() > 0) begin
         e_sc_rx = mq[0][1] && mq[0][0];
         e_pf_rx = mq[0][1] && !mq[0][0];
      end
      e_fetch = !e_sc_tx || write_pc;
      e_jump  = write_pc;
      e_idle  = bus.tx_active ? m_curr_sc : sc_block;
   endtask

   task automatic model_next();
      int pre = mq.size();
      if (bus.rx_done) begin
         if (pre == 0) m_err = 1;
         else          void'(mq.pop_front());
      end
      if (bus.tx_command_started && e_cmd == TX_HEADER_READ_16)
         mq.push_back({e_sc_tx ? sc_reply_wanted : 1'b1, e_sc_tx && !write_pc});
      if (bus.tx_command_started) begin
         if (!e_sc_tx)                               m_starve = 0;
         else if (pf_cmd_valid && m_starve < STARVE) m_starve++;
      end
      if (!bus.tx_active) m_curr_sc = e_want;
   endtask

   task automatic check_all(string tag);
      chk({tag, ".sc_tx"},   sc_tx,                e_sc_tx);
      chk({tag, ".valid"},   bus.tx_command_valid, e_valid);
      chk({tag, ".cmd"},     bus.tx_command,       e_cmd);
      chk({tag, ".data"},    bus.tx_data,          e_data);
      chk({tag, ".sc_rx"},   sc_rx,                e_sc_rx);
      chk({tag, ".pf_rx"},   pf_rx,                e_pf_rx);
      chk({tag, ".fetch"},   tx_fetch,             e_fetch);
      chk({tag, ".jump"},    tx_jump,              e_jump);
      chk({tag, ".idle"},    prefetch_idle,        e_idle);
      chk({tag, ".full"},    full,                 e_full);
      chk({tag, ".empty"},   empty,                e_empty);
      chk({tag, ".outst"},   outstanding,          e_out);
      chk({tag, ".err"},     err_underflow,        m_err);
   endtask

   task automatic settle(string tag);
      @(negedge clk);
      model_comb();
      check_all(tag);
   endtask

   task automatic advance();
      model_next();
      @(posedge clk);
      #1;
   endtask

   task automatic tick(string tag);
      settle(tag);
      advance();
   endtask

   task automatic clear_inputs();
      pf_cmd_valid = 0; pf_cmd = TX_HEADER_WRITE_8; pf_data = 0;
      sc_cmd_valid = 0; sc_cmd = TX_HEADER_WRITE_8; sc_data = 0;
      sc_reply_wanted = 0; sc_reserve = 0; sc_block = 0; write_pc = 0;
      bus.tx_command_started = 0; bus.tx_active = 0; bus.rx_done = 0;
   endtask

   function automatic logic [TX_CMD_BITS-1:0] pick_cmd();
      int r = $urandom_range(0, 3);
      if (r < 2)  return TX_HEADER_READ_16;
      if (r == 2) return TX_HEADER_WRITE_16;
      return TX_HEADER_WRITE_8;
   endfunction

   int busy_left;

   initial begin
      clear_inputs();
      reset = 1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 0;

      // Reset state
      settle("reset");
      chk("reset.empty", empty, 1'b1);
      chk("reset.outst", outstanding, 3'd0);
      advance();

      // PF read alone
      pf_cmd_valid = 1; pf_cmd = TX_HEADER_READ_16; pf_data = 2'b10;
      bus.tx_command_started = 1;
      settle("pf_rd");
      chk("pf_rd.sc_tx", sc_tx, 1'b0);
      chk("pf_rd.valid", bus.tx_command_valid, 1'b1);
      advance();
      bus.tx_command_started = 0; bus.tx_active = 1; pf_cmd_valid = 0;
      tick("pf_rd.act");
      bus.tx_active = 0; bus.rx_done = 1;
      settle("pf_rd.rx");
      chk("pf_rd.pf_rx", pf_rx, 1'b1);
      chk("pf_rd.outst", outstanding, 3'd1);
      advance();
      bus.rx_done = 0;
      settle("pf_rd.post");
      chk("pf_rd.empty", empty, 1'b1);
      advance();

      // SC priority, ownership frozen during a message
      sc_cmd_valid = 1; sc_cmd = TX_HEADER_WRITE_16; sc_data = 2'b01;
      pf_cmd_valid = 1; pf_cmd = TX_HEADER_READ_16;
      bus.tx_command_started = 1;
      settle("prio");
      chk("prio.sc_tx", sc_tx, 1'b1);
      advance();
      bus.tx_command_started = 0; bus.tx_active = 1; sc_cmd_valid = 0;
      settle("hold");
      chk("hold.sc_tx", sc_tx, 1'b1);
      advance();
      tick("hold2");
      bus.tx_active = 0;
      settle("release");
      chk("release.sc_tx", sc_tx, 1'b0);
      advance();

      // Fill FIFO with PF reads
      for (int i = 0; i < 4; i++) begin
         bus.tx_command_started = 1;
         tick("fill.st");
         bus.tx_command_started = 0; bus.tx_active = 1;
         tick("fill.act");
         bus.tx_active = 0;
      end
      settle("full");
      chk("full.full", full, 1'b1);
      chk("full.rd_blocked", bus.tx_command_valid, 1'b0);
      advance();
      sc_cmd_valid = 1; sc_cmd = TX_HEADER_WRITE_16;
      settle("full.wr");
      chk("full.wr_valid", bus.tx_command_valid, 1'b1);
      advance();
      sc_cmd_valid = 0; bus.rx_done = 1;
      tick("full.pop");
      bus.rx_done = 0;
      settle("full.after");
      chk("full.rd_ok", bus.tx_command_valid, 1'b1);
      chk("full.outst", outstanding, 3'd3);
      advance();
      pf_cmd_valid = 0;
      for (int i = 0; i < 3; i++) begin
         bus.rx_done = 1; tick("drain");
         bus.rx_done = 0; tick("drain.gap");
      end

      // SC jump fetch goes to PF
      sc_cmd_valid = 1; sc_cmd = TX_HEADER_READ_16; write_pc = 1; sc_reply_wanted = 1;
      bus.tx_command_started = 1;
      settle("jump");
      chk("jump.fetch", tx_fetch, 1'b1);
      chk("jump.jump", tx_jump, 1'b1);
      advance();
      bus.tx_command_started = 0; bus.tx_active = 1;
      tick("jump.act");
      bus.tx_active = 0; sc_cmd_valid = 0; write_pc = 0; bus.rx_done = 1;
      settle("jump.rx");
      chk("jump.pf_rx", pf_rx, 1'b1);
      chk("jump.sc_rx", sc_rx, 1'b0);
      advance();
      bus.rx_done = 0;

      // SC read with reply discarded
      sc_cmd_valid = 1; sc_cmd = TX_HEADER_READ_16; sc_reply_wanted = 0;
      bus.tx_command_started = 1;
      tick("disc.st");
      bus.tx_command_started = 0; bus.tx_active = 1;
      tick("disc.act");
      bus.tx_active = 0; sc_cmd_valid = 0;
      settle("disc.rx");
      chk("disc.outst", outstanding, 3'd1);
      chk("disc.sc_rx", sc_rx, 1'b0);
      chk("disc.pf_rx", pf_rx, 1'b0);
      advance();
      bus.rx_done = 1; tick("disc.pop");
      bus.rx_done = 0;

      // Underflow
      bus.rx_done = 1; tick("uflow");
      bus.rx_done = 0;
      settle("uflow.post");
      chk("uflow.err", err_underflow, 1'b1);
      chk("uflow.outst", outstanding, 3'd0);
      advance();

      // Asynchronous reset in the middle of a PF read message
      pf_cmd_valid = 1; pf_cmd = TX_HEADER_READ_16;
      bus.tx_command_started = 1; tick("rst.st");
      bus.tx_command_started = 0; bus.tx_active = 1; tick("rst.act");
      reset = 1;
      #1;
      chk("rst.outst", outstanding, 3'd0);
      chk("rst.empty", empty, 1'b1);
      chk("rst.full", full, 1'b0);
      chk("rst.err", err_underflow, 1'b0);
      chk("rst.sc_tx", sc_tx, 1'b0);
      chk("rst.pf_rx", pf_rx, 1'b0);
      model_reset();
      clear_inputs();
      @(posedge clk);
      #1 reset = 0;

`ifdef MEM_ARB_FAIR_EN
      // Starvation: three SC messages then one PF message
      sc_cmd_valid = 1; sc_cmd = TX_HEADER_WRITE_16;
      pf_cmd_valid = 1; pf_cmd = TX_HEADER_READ_16;
      for (int i = 0; i < 4; i++) begin
         bus.tx_command_started = 1;
         settle("fair.st");
         chk("fair.order", sc_tx, (i < 3) ? 1'b1 : 1'b0);
         advance();
         bus.tx_command_started = 0; bus.tx_active = 1;
         tick("fair.act");
         bus.tx_active = 0;
      end
      sc_block = 1;
      for (int i = 0; i < 5; i++) begin
         bus.tx_command_started = 1;
         settle("blk.st");
         chk("blk.sc_tx", sc_tx, 1'b1);
         advance();
         bus.tx_command_started = 0; bus.tx_active = 1;
         tick("blk.act");
         bus.tx_active = 0;
      end
      clear_inputs();
`endif

      // Randomized traffic
      busy_left = 0;
      for (int c = 0; c < 1500; c++) begin
         pf_cmd_valid    = ($urandom_range(0, 1) == 1);
         pf_cmd          = pick_cmd();
         pf_data         = 2'($urandom);
         sc_cmd_valid    = ($urandom_range(0, 2) == 0);
         sc_cmd          = pick_cmd();
         sc_data         = 2'($urandom);
         sc_reply_wanted = ($urandom_range(0, 1) == 1);
         sc_reserve      = ($urandom_range(0, 7) == 0);
         sc_block        = ($urandom_range(0, 7) == 0);
         write_pc        = ($urandom_range(0, 3) == 0);
         bus.rx_done     = (!bus.rx_done && mq.size() > 0 && $urandom_range(0, 2) == 0);
         if (busy_left > 0) begin
            bus.tx_active          = 1;
            bus.tx_command_started = 0;
            busy_left--;
         end else begin
            bus.tx_active = 0;
            model_comb();
            if (e_valid && $urandom_range(0, 2) != 0) begin
               bus.tx_command_started = 1;
               busy_left = $urandom_range(1, 3);
            end else begin
               bus.tx_command_started = 0;
            end
         end
         tick("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
